// File: rtl/psum_pkg.sv
// Shared widths, derivations and arithmetic helpers for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned CH_DEF     = 64;
  localparam int unsigned GROUPS_DEF = 2;
  localparam int unsigned IN_W_DEF   = 4;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 4;

  // Helpers work on a fixed wide signed value so any lane width fits.
  localparam int unsigned CALC_W = 32;

  typedef struct packed {
    logic                     ovf;
    logic signed [CALC_W-1:0] val;
  } sat_res_t;

  function automatic int unsigned sum_w(input int unsigned in_w, input int unsigned groups);
    return in_w + $clog2(groups);
  endfunction

  function automatic int unsigned acc_w(input int unsigned s_w, input int unsigned cnt_w);
    return s_w + cnt_w;
  endfunction

  // Optional decode: keep the sign bit, invert the magnitude bits of a w-bit element.
  function automatic logic signed [CALC_W-1:0] decode(input logic [CALC_W-1:0] d,
                                                      input int unsigned w,
                                                      input logic en);
    logic [CALC_W-1:0] mask;
    mask = (CALC_W'(1) << (w - 1)) - CALC_W'(1);
    return en ? $signed(d ^ mask) : $signed(d);
  endfunction

  // Reduce a wide signed value to w bits: clamp or wrap, flagging out-of-range inputs.
  function automatic sat_res_t saturate(input logic signed [CALC_W-1:0] v,
                                        input int unsigned w,
                                        input logic sat);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_res_t                 r;
    hi    = $signed((CALC_W'(1) << (w - 1)) - CALC_W'(1));
    lo    = ~hi;
    r.ovf = (v > hi) || (v < lo);
    if (!sat)        r.val = (v <<< (CALC_W - w)) >>> (CALC_W - w);
    else if (v > hi) r.val = hi;
    else if (v < lo) r.val = lo;
    else             r.val = v;
    return r;
  endfunction

endpackage

// File: rtl/partial_sum_acc_if.sv
// Input-beat / output-window handshake bundle for the partial-sum accumulator.
interface partial_sum_acc_if
  import psum_pkg::*;
#(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned GROUPS = GROUPS_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic                                   in_valid;
  logic                                   in_ready;
  logic [GROUPS-1:0][CH-1:0][IN_W-1:0]    in_data;
  logic                                   in_last;
  logic                                   decode_en;
  logic                                   sat_en;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [CH-1:0][OUT_W-1:0]               out_data;
  logic [CNT_W:0]                         out_beats;
  logic                                   out_ovf;
  logic                                   out_lenerr;

  modport master (
    output in_valid, in_data, in_last, decode_en, sat_en, out_ready,
    input  in_ready, out_valid, out_data, out_beats, out_ovf, out_lenerr
  );

  modport slave (
    input  in_valid, in_data, in_last, decode_en, sat_en, out_ready,
    output in_ready, out_valid, out_data, out_beats, out_ovf, out_lenerr
  );

endinterface

// File: rtl/psum_lane.sv
// One channel: decode and sum the groups, accumulate the window, reduce to OUT_W.
module psum_lane
  import psum_pkg::*;
#(
  parameter int unsigned GROUPS = GROUPS_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [GROUPS-1:0][IN_W-1:0]  d,
  input  logic                         dec,
  input  logic                         acc_en,
  input  logic                         first,
  input  logic                         sat,
  input  logic                         out_load,
  output logic [OUT_W-1:0]             res,
  output logic                         ovf_c
);

  localparam int unsigned SUM_W = sum_w(IN_W, GROUPS);
  localparam int unsigned ACC_W = acc_w(SUM_W, CNT_W);

  logic signed [IN_W-1:0]  elem;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] s1;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  sat_res_t                sr;

  // Stage-1 adder across groups.
  always_comb begin
    elem  = '0;
    sum_c = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      elem  = IN_W'(decode(CALC_W'(d[g]), IN_W, dec));
      sum_c = sum_c + SUM_W'(elem);
    end
  end

  // Window accumulation and output reduction.
  always_comb begin
    acc_next = first ? ACC_W'(s1) : acc + ACC_W'(s1);
    sr       = saturate(CALC_W'(acc_next), OUT_W, sat);
    ovf_c    = sr.ovf;
  end

  // Pipeline registers; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      acc <= '0;
      res <= '0;
    end else begin
      if (en)       s1  <= sum_c;
      if (acc_en)   acc <= acc_next;
      if (out_load) res <= OUT_W'(sr.val);
    end
  end

endmodule

// File: rtl/partial_sum_acc.sv
// Windowed per-channel partial-sum accumulator with valid/ready backpressure.
module partial_sum_acc
  import psum_pkg::*;
#(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned GROUPS = GROUPS_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  partial_sum_acc_if.slave  bus
);

  localparam int unsigned MAX_BEATS = 2 ** CNT_W;

  logic                     adv;
  logic                     accept;
  logic [CNT_W:0]           in_cnt;
  logic                     in_first;
  logic                     full_c;
  logic                     close_c;
  logic                     dec_win;
  logic                     sat_win;
  logic                     dec_cur;
  logic                     sat_cur;
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_close;
  logic                     s1_lenerr;
  logic                     s1_sat;
  logic [CNT_W:0]           s1_beats;
  logic                     acc_en;
  logic                     out_load;
  logic                     out_valid;
  logic [CH-1:0]            ovf_c;
  logic [CH-1:0][OUT_W-1:0] out_data;

  // Whole pipeline advances only when no finished window is stuck at the output.
  assign adv          = !rst && !(out_valid && !bus.out_ready);
  assign bus.in_ready = adv;
  assign accept       = bus.in_valid && adv;

  assign in_first = (in_cnt == '0);
  assign full_c   = (in_cnt == (CNT_W+1)'(MAX_BEATS - 1));
  assign close_c  = bus.in_last || full_c;
  assign dec_cur  = in_first ? bus.decode_en : dec_win;
  assign sat_cur  = in_first ? bus.sat_en    : sat_win;
  assign acc_en   = s1_valid && adv;
  assign out_load = acc_en && s1_close;

  // Input-side window tracking: beat count and per-window mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      dec_win <= 1'b0;
      sat_win <= 1'b0;
    end else if (accept) begin
      if (in_first) begin
        dec_win <= bus.decode_en;
        sat_win <= bus.sat_en;
      end
      in_cnt <= close_c ? '0 : in_cnt + (CNT_W+1)'(1);
    end
  end

  // Stage-1 control sideband travelling with the lane sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_close  <= 1'b0;
      s1_lenerr <= 1'b0;
      s1_sat    <= 1'b0;
      s1_beats  <= '0;
    end else if (adv) begin
      s1_valid  <= bus.in_valid;
      s1_first  <= in_first;
      s1_close  <= close_c;
      s1_lenerr <= !bus.in_last && full_c;
      s1_sat    <= sat_cur;
      s1_beats  <= in_cnt + (CNT_W+1)'(1);
    end
  end

  // Output window register and its valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      bus.out_beats  <= '0;
      bus.out_ovf    <= 1'b0;
      bus.out_lenerr <= 1'b0;
    end else if (out_load) begin
      out_valid      <= 1'b1;
      bus.out_beats  <= s1_beats;
      bus.out_ovf    <= |ovf_c;
      bus.out_lenerr <= s1_lenerr;
    end else if (bus.out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [GROUPS-1:0][IN_W-1:0] d_c;
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      assign d_c[g] = bus.in_data[g][c];
    end
    psum_lane #(
      .GROUPS (GROUPS),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .d        (d_c),
      .dec      (dec_cur),
      .acc_en   (acc_en),
      .first    (s1_first),
      .sat      (s1_sat),
      .out_load (out_load),
      .res      (out_data[c]),
      .ovf_c    (ovf_c[c])
    );
  end

endmodule
